// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU tile scheduler.
//   TILE      : systolic array edge length (only 4 is supported)
//   ADDR_BITS : global buffer index width
//   TCNT_W    : tile-count width, holds 1..64
//   state_t   : scheduler state encoding
package tpu_pkg;

   localparam int unsigned TILE      = 4;
   localparam int unsigned ADDR_BITS = 16;
   localparam int unsigned TCNT_W    = 7;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StIssue,
      StWait,
      StWrite,
      StDone
   } state_t;

endpackage

// File: rtl/tpu_tile_counter.sv
// Nested tile counters: n_tile is the inner loop, m_tile the outer loop.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : restart both counters at tile (0,0)
//   i_advance      : step to the next tile in row-major order
//   i_tiles_m/n    : tile counts of the current job (1..64)
//   o_n_last       : current n_tile is the last column of tiles
//   o_last         : current tile is the final tile of the job
module tpu_tile_counter
   import tpu_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clear,
   input  logic              i_advance,
   input  logic [TCNT_W-1:0] i_tiles_m,
   input  logic [TCNT_W-1:0] i_tiles_n,
   output logic              o_n_last,
   output logic              o_last
);

   logic [TCNT_W-1:0] r_m_tile;
   logic [TCNT_W-1:0] r_n_tile;
   logic              w_m_last;

   assign o_n_last = (r_n_tile == i_tiles_n - TCNT_W'(1));
   assign w_m_last = (r_m_tile == i_tiles_m - TCNT_W'(1));
   assign o_last   = o_n_last && w_m_last;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_m_tile <= '0;
         r_n_tile <= '0;
      end else if (i_clear) begin
         r_m_tile <= '0;
         r_n_tile <= '0;
      end else if (i_advance) begin
         if (o_n_last) begin
            r_n_tile <= '0;
            r_m_tile <= r_m_tile + TCNT_W'(1);
         end else begin
            r_n_tile <= r_n_tile + TCNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/tpu_tile_scheduler.sv
// Tile scheduler for a TILE x TILE systolic array: walks the C = A*B job
// tile by tile, launches each tile, then streams its four local C rows
// back to the global buffer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, K, M, N   : job request and dimensions (A is MxK, B is KxN)
//   busy, done          : job in progress / one-cycle end-of-job pulse
//   sa_start            : one-cycle tile launch pulse
//   sa_a_base/b_base    : A/B base indices of the current tile
//   sa_k_len            : accumulation depth (latched K)
//   sa_done             : tile-complete pulse from the array
//   C_wr_en, C_index    : C write strobe and index
//   c_row_sel           : local C row driving the write data
module tpu_tile_scheduler #(
   parameter int unsigned TILE      = tpu_pkg::TILE,
   parameter int unsigned ADDR_BITS = tpu_pkg::ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [7:0]           K,
   input  logic [7:0]           M,
   input  logic [7:0]           N,
   output logic                 busy,
   output logic                 done,
   output logic                 sa_start,
   output logic [ADDR_BITS-1:0] sa_a_base,
   output logic [ADDR_BITS-1:0] sa_b_base,
   output logic [7:0]           sa_k_len,
   input  logic                 sa_done,
   output logic                 C_wr_en,
   output logic [ADDR_BITS-1:0] C_index,
   output logic [1:0]           c_row_sel
);

   import tpu_pkg::*;

   localparam int unsigned TILE_SH = $clog2(TILE);

   state_t               r_state;
   logic [7:0]           r_k;
   logic [7:0]           r_m;
   logic [7:0]           r_n;
   logic [TCNT_W-1:0]    r_tiles_m;
   logic [TCNT_W-1:0]    r_tiles_n;
   logic [9:0]           r_m_row;        // m_tile * TILE
   logic [ADDR_BITS-1:0] r_c_row_base;   // m_tile * TILE * tiles_N
   logic [ADDR_BITS-1:0] r_c_tile_base;  // r_c_row_base + n_tile

   logic                 w_n_last;
   logic                 w_last;
   logic                 w_clear;
   logic                 w_advance;
   logic                 w_zero_dim;
   logic                 w_last_row;
   logic [TCNT_W-1:0]    w_tiles_m;
   logic [TCNT_W-1:0]    w_tiles_n;
   logic [9:0]           w_next_row;
   logic [ADDR_BITS-1:0] w_tn_step;
   logic [ADDR_BITS-1:0] w_tn_row_step;

   assign w_tiles_m     = TCNT_W'((9'(r_m) + 9'(TILE - 1)) >> TILE_SH);
   assign w_tiles_n     = TCNT_W'((9'(r_n) + 9'(TILE - 1)) >> TILE_SH);
   assign w_zero_dim    = (r_k == 8'd0) || (r_m == 8'd0) || (r_n == 8'd0);
   assign w_last_row    = (c_row_sel == 2'd3);
   assign w_next_row    = r_m_row + 10'(c_row_sel) + 10'd1;
   assign w_tn_step     = ADDR_BITS'(r_tiles_n);
   assign w_tn_row_step = w_tn_step << TILE_SH;

   assign w_clear   = (r_state == StSetup);
   assign w_advance = (r_state == StWrite) && w_last_row && !w_last;

   tpu_tile_counter u_tile_counter (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_clear   (w_clear),
      .i_advance (w_advance),
      .i_tiles_m (r_tiles_m),
      .i_tiles_n (r_tiles_n),
      .o_n_last  (w_n_last),
      .o_last    (w_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= StIdle;
         r_k           <= '0;
         r_m           <= '0;
         r_n           <= '0;
         r_tiles_m     <= '0;
         r_tiles_n     <= '0;
         r_m_row       <= '0;
         r_c_row_base  <= '0;
         r_c_tile_base <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         sa_start      <= 1'b0;
         sa_a_base     <= '0;
         sa_b_base     <= '0;
         sa_k_len      <= '0;
         C_wr_en       <= 1'b0;
         C_index       <= '0;
         c_row_sel     <= '0;
      end else begin
         sa_start <= 1'b0;
         done     <= 1'b0;
         case (r_state)
            StIdle: begin
               if (in_valid) begin
                  r_k     <= K;
                  r_m     <= M;
                  r_n     <= N;
                  busy    <= 1'b1;
                  r_state <= StSetup;
               end
            end
            StSetup: begin
               r_tiles_m <= w_tiles_m;
               r_tiles_n <= w_tiles_n;
               if (w_zero_dim) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= StDone;
               end else begin
                  sa_start      <= 1'b1;
                  sa_a_base     <= '0;
                  sa_b_base     <= '0;
                  sa_k_len      <= r_k;
                  r_m_row       <= '0;
                  r_c_row_base  <= '0;
                  r_c_tile_base <= '0;
                  r_state       <= StIssue;
               end
            end
            StIssue: begin
               // sa_done sampled here belongs to no launched tile yet
               r_state <= StWait;
            end
            StWait: begin
               if (sa_done) begin
                  c_row_sel <= 2'd0;
                  C_index   <= r_c_tile_base;
                  C_wr_en   <= (r_m_row < 10'(r_m));
                  r_state   <= StWrite;
               end
            end
            StWrite: begin
               if (!w_last_row) begin
                  c_row_sel <= c_row_sel + 2'd1;
                  C_index   <= C_index + w_tn_step;
                  // rows past M in a ragged bottom tile still take a cycle
                  C_wr_en   <= (w_next_row < 10'(r_m));
               end else begin
                  C_wr_en <= 1'b0;
                  if (w_last) begin
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     r_state <= StDone;
                  end else begin
                     sa_start <= 1'b1;
                     r_state  <= StIssue;
                     if (w_n_last) begin
                        sa_a_base     <= sa_a_base + ADDR_BITS'(r_k);
                        sa_b_base     <= '0;
                        r_m_row       <= r_m_row + 10'(TILE);
                        r_c_row_base  <= r_c_row_base + w_tn_row_step;
                        r_c_tile_base <= r_c_row_base + w_tn_row_step;
                     end else begin
                        sa_b_base     <= sa_b_base + ADDR_BITS'(r_k);
                        r_c_tile_base <= r_c_tile_base + ADDR_BITS'(1);
                     end
                  end
               end
            end
            StDone: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
module tb_tpu_tile_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        sa_done_i;
   logic [7:0]  in_k, in_m, in_n;
   logic        busy, done, sa_start, c_wr_en;
   logic [15:0] a_base, b_base, c_index;
   logic [7:0]  k_len;
   logic [1:0]  row_sel;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   tpu_tile_scheduler #(.TILE(4), .ADDR_BITS(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .K         (in_k),
      .M         (in_m),
      .N         (in_n),
      .busy      (busy),
      .done      (done),
      .sa_start  (sa_start),
      .sa_a_base (a_base),
      .sa_b_base (b_base),
      .sa_k_len  (k_len),
      .sa_done   (sa_done_i),
      .C_wr_en   (c_wr_en),
      .C_index   (c_index),
      .c_row_sel (row_sel)
   );

   typedef struct { int unsigned a; int unsigned b; } tile_t;
   typedef struct { int unsigned idx; int unsigned row; } wr_t;
   typedef struct { int m; int n; int k; int dmax; bit ab; int e_tiles; int e_wr; } vec_t;

   tile_t       exp_tiles[$];
   wr_t         exp_wrs[$];
   int unsigned exp_last;
   vec_t        vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain nested loops over the job's tiles and rows.
   function automatic void build_model(input int m, input int n, input int k);
      int tm, tn, row;
      exp_tiles.delete();
      exp_wrs.delete();
      exp_last = 0;
      if (m == 0 || n == 0 || k == 0) return;
      tm = (m + 3) / 4;
      tn = (n + 3) / 4;
      for (int mt = 0; mt < tm; mt++) begin
         for (int nt = 0; nt < tn; nt++) begin
            exp_tiles.push_back('{a: mt * k, b: nt * k});
            for (int r = 0; r < 4; r++) begin
               row = mt * 4 + r;
               if (row < m) exp_wrs.push_back('{idx: row * tn + nt, row: r});
            end
         end
      end
      exp_last = ((tm - 1) * 4 + 3) * tn + (tn - 1);
   endfunction

   task automatic pulse_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      sa_done_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Runs one job acting as the systolic array; compares against the model.
   task automatic run_job(input int m, input int n, input int k, input int dmax, input bit ab,
                          output int n_tiles, output int n_wr);
      int cyc, ti, wi, cd, sd_cyc, budget;
      bit pending, finished, busy_ok, zero;
      build_model(m, n, k);
      zero     = (exp_tiles.size() == 0);
      budget   = (exp_tiles.size() + 1) * (8 + dmax) + 20;
      ti       = 0;
      wi       = 0;
      cd       = 0;
      sd_cyc   = -100;
      pending  = 1'b0;
      finished = 1'b0;
      busy_ok  = 1'b1;
      @(negedge clk);
      in_valid = 1'b1;
      in_m = 8'(m);
      in_n = 8'(n);
      in_k = 8'(k);
      @(negedge clk);
      in_valid = 1'b0;
      in_m = 8'($urandom);
      in_n = 8'($urandom);
      in_k = 8'($urandom);
      cyc = 1;
      while (!finished && cyc <= budget) begin
         if (cyc == 1) check("accept_busy", busy, 1);
         if (cyc == sd_cyc + 1) begin
            check("first_wr_en", c_wr_en, 1);
            check("first_wr_row", row_sel, 0);
         end
         if (c_wr_en) begin
            if (wi < exp_wrs.size()) begin
               check("wr_index", c_index, exp_wrs[wi].idx);
               check("wr_row", row_sel, exp_wrs[wi].row);
            end
            wi++;
         end
         if (sa_start) begin
            if (ti == 0) check("first_start_lat", cyc, 2);
            else check("write_len", cyc - sd_cyc, 5);
            if (ti < exp_tiles.size()) begin
               check("a_base", a_base, exp_tiles[ti].a);
               check("b_base", b_base, exp_tiles[ti].b);
               check("k_len", k_len, k);
            end
            ti++;
            pending = 1'b1;
            cd = $urandom_range(0, dmax);
         end
         if (done) begin
            finished = 1'b1;
            check("done_busy_low", busy, 0);
            if (zero) begin
               check("zero_done_lat", cyc, 2);
            end else begin
               check("done_gap", cyc - sd_cyc, 5);
               check("last_cindex", c_index, exp_last);
            end
         end else if (busy !== 1'b1) begin
            busy_ok = 1'b0;
         end
         sa_done_i = 1'b0;
         in_valid  = 1'b0;
         if (!finished) begin
            if (ab && $urandom_range(0, 1) == 1) begin
               in_valid = 1'b1;
               in_m = 8'($urandom);
               in_n = 8'($urandom);
               in_k = 8'($urandom);
            end
            if (sa_start) begin
               if (ab) sa_done_i = 1'b1;  // lands in ISSUE, must be ignored
            end else if (pending) begin
               if (cd == 0) begin
                  sa_done_i = 1'b1;
                  pending = 1'b0;
                  sd_cyc = cyc;
               end else begin
                  cd--;
               end
            end else if (ab) begin
               sa_done_i = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
         end
      end
      check("job_finished", finished, 1);
      if (!finished) pulse_reset();
      check("tile_count", ti, exp_tiles.size());
      check("write_count", wi, exp_wrs.size());
      check("busy_hold", busy_ok, 1);
      n_tiles = ti;
      n_wr = wi;
   endtask

   initial begin
      int nt, nw, starts, m, n, k;
      bit pend;
      rst_n = 1'b0;
      in_valid = 1'b0;
      sa_done_i = 1'b0;
      in_k = '0;
      in_m = '0;
      in_n = '0;

      //          m    n    k  dmax ab tiles writes
      vecs[0] = '{4,   4,   4,  1, 0,    1,     4};
      vecs[1] = '{6,   8,   3,  2, 0,    4,    12};
      vecs[2] = '{4,   4,   0,  0, 0,    0,     0};
      vecs[3] = '{1,   1,   1,  0, 0,    1,     1};
      vecs[4] = '{5,   3,   7,  3, 0,    2,     5};
      vecs[5] = '{0,   3,   5,  0, 0,    0,     0};
      vecs[6] = '{9,   0,   2,  0, 0,    0,     0};
      vecs[7] = '{8,   5,   9,  2, 1,    4,    16};
      vecs[8] = '{13, 17,   2,  1, 0,   20,    65};
      vecs[9] = '{255, 255, 255, 0, 0, 4096, 16320};

      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sa_start", sa_start, 0);
      check("rst_wr_en", c_wr_en, 0);
      check("rst_a_base", a_base, 0);
      check("rst_b_base", b_base, 0);
      check("rst_cindex", c_index, 0);
      check("rst_k_len", k_len, 0);
      check("rst_row_sel", row_sel, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run_job(vecs[i].m, vecs[i].n, vecs[i].k, vecs[i].dmax, vecs[i].ab, nt, nw);
         check("tbl_tiles", nt, vecs[i].e_tiles);
         check("tbl_writes", nw, vecs[i].e_wr);
      end

      for (int i = 0; i < 15; i++) begin
         m = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
         n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
         k = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 255);
         run_job(m, n, k, $urandom_range(0, 3), 1'($urandom_range(0, 1)), nt, nw);
      end

      // Reset while waiting on the third tile of an 8x8x8 job.
      @(negedge clk);
      in_valid = 1'b1;
      in_m = 8'd8;
      in_n = 8'd8;
      in_k = 8'd8;
      @(negedge clk);
      in_valid = 1'b0;
      starts = 0;
      pend = 1'b0;
      for (int i = 0; i < 80 && starts < 3; i++) begin
         sa_done_i = 1'b0;
         if (sa_start) begin
            starts++;
            pend = 1'b1;
         end else if (pend) begin
            sa_done_i = 1'b1;
            pend = 1'b0;
         end
         if (starts < 3) @(negedge clk);
      end
      check("rst_seq_starts", starts, 3);
      check("rst_seq_a_base", a_base, 8);
      sa_done_i = 1'b0;
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_k_len", k_len, 0);
      check("mid_rst_a_base", a_base, 0);
      check("mid_rst_cindex", c_index, 0);
      check("mid_rst_row_sel", row_sel, 0);
      sa_done_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("in_rst_wr_en", c_wr_en, 0);
      sa_done_i = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_wr_en", c_wr_en, 0);
      sa_done_i = 1'b1;
      @(negedge clk);
      sa_done_i = 1'b0;
      @(negedge clk);
      check("idle_sa_done_busy", busy, 0);
      check("idle_sa_done_wr", c_wr_en, 0);
      run_job(4, 4, 4, 1, 1'b0, nt, nw);
      check("post_rst_tiles", nt, 1);
      check("post_rst_writes", nw, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
